// File: rtl/string_accel_pkg.sv
// Shared types and CTRL register bit positions for the string accelerator.
package string_accel_pkg;

  localparam int unsigned CHARS_PER_WORD = 4;

  localparam int unsigned CtrlGo      = 0;
  localparam int unsigned CtrlDone    = 1;
  localparam int unsigned CtrlBusy    = 2;
  localparam int unsigned CtrlModeLo  = 3;
  localparam int unsigned CtrlWrErr   = 5;
  localparam int unsigned CtrlNoterm  = 6;
  localparam int unsigned CtrlIe      = 7;
  localparam int unsigned CtrlIndexLo = 8;

  typedef enum logic [1:0] {
    ModeStrlen = 2'b00,
    ModeStrcmp = 2'b01,
    ModeStrcpy = 2'b10,
    ModeRsvd   = 2'b11
  } mode_t;

  typedef enum logic {
    StIdle,
    StScan
  } state_t;

endpackage

// File: rtl/string_word_scan.sv
// Combinational per-word scanner: finds the lowest terminating or differing byte of a word.
module string_word_scan
  import string_accel_pkg::*;
(
  input  logic [31:0] a_word_i,
  input  logic [31:0] b_word_i,
  input  mode_t       mode_i,
  output logic        hit_o,
  output logic [1:0]  byte_idx_o,
  output logic [8:0]  diff_o
);

  logic [7:0] a_c;
  logic [7:0] b_c;

  always_comb begin
    hit_o      = 1'b0;
    byte_idx_o = 2'd0;
    diff_o     = '0;
    a_c        = '0;
    b_c        = '0;
    // Walk high to low so the lowest matching byte wins.
    for (int n = CHARS_PER_WORD - 1; n >= 0; n--) begin
      a_c = a_word_i[8*n +: 8];
      b_c = b_word_i[8*n +: 8];
      if (a_c == 8'h00 || (mode_i == ModeStrcmp && a_c != b_c)) begin
        hit_o      = 1'b1;
        byte_idx_o = 2'(n);
        diff_o     = {1'b0, a_c} - {1'b0, b_c};
      end
    end
  end

endmodule

// File: rtl/string_accel_avalon.sv
// Avalon-MM string accelerator (STRLEN/STRCMP/STRCPY), one word per clock.
// Define STRING_ACCEL_IRQ_EN to add the level irq output and the IE control bit.
module string_accel_avalon
  import string_accel_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
`ifdef STRING_ACCEL_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned KW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [KW-1:0] KLast = KW'(MAX_WORDS - 1);

  logic [31:0] a_q [MAX_WORDS];
  logic [31:0] b_q [MAX_WORDS];
  state_t      state_q;
  mode_t       ctrl_mode_q, run_mode_q;
  logic [KW-1:0] k_q;
  logic        done_q, wr_err_q, noterm_q, ie_q;
  logic [7:0]  index_q;
  logic [31:0] result_q;

  logic        sel_ctrl, sel_a, sel_b, sel_res, wr_en, busy;
  logic [KW-1:0] a_idx, b_idx;
  logic [31:0] ctrl_rd, rd_data;
  logic        scan_hit;
  logic [1:0]  scan_byte;
  logic [8:0]  scan_diff;
  logic [7:0]  hit_index;

  assign busy      = (state_q == StScan);
  assign wr_en     = chipselect & write;
  assign sel_ctrl  = (address == '0);
  assign sel_a     = (address >= ADDR_W'(1)) && (address <= ADDR_W'(MAX_WORDS));
  assign sel_b     = (address > ADDR_W'(MAX_WORDS)) && (address <= ADDR_W'(2 * MAX_WORDS));
  assign sel_res   = (address == ADDR_W'(2 * MAX_WORDS + 1));
  assign a_idx     = KW'(address - ADDR_W'(1));
  assign b_idx     = KW'(address - ADDR_W'(MAX_WORDS + 1));
  assign hit_index = 8'({k_q, scan_byte});

  string_word_scan u_scan (
    .a_word_i   (a_q[k_q]),
    .b_word_i   (b_q[k_q]),
    .mode_i     (run_mode_q),
    .hit_o      (scan_hit),
    .byte_idx_o (scan_byte),
    .diff_o     (scan_diff)
  );

  always_comb begin
    ctrl_rd                     = '0;
    ctrl_rd[CtrlDone]           = done_q;
    ctrl_rd[CtrlBusy]           = busy;
    ctrl_rd[CtrlModeLo +: 2]    = ctrl_mode_q;
    ctrl_rd[CtrlWrErr]          = wr_err_q;
    ctrl_rd[CtrlNoterm]         = noterm_q;
    ctrl_rd[CtrlIe]             = ie_q;
    ctrl_rd[CtrlIndexLo +: 8]   = noterm_q ? 8'h00 : index_q;
    rd_data = '0;
    if (sel_ctrl)     rd_data = ctrl_rd;
    else if (sel_a)   rd_data = a_q[a_idx];
    else if (sel_b)   rd_data = b_q[b_idx];
    else if (sel_res) rd_data = result_q;
  end

`ifndef STRING_ACCEL_IRQ_EN
  assign ie_q = 1'b0;
`else
  assign irq = done_q & ie_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_WORDS); i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      state_q       <= StIdle;
      ctrl_mode_q   <= ModeStrlen;
      run_mode_q    <= ModeStrlen;
      k_q           <= '0;
      done_q        <= 1'b0;
      wr_err_q      <= 1'b0;
      noterm_q      <= 1'b0;
      index_q       <= '0;
      result_q      <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
`ifdef STRING_ACCEL_IRQ_EN
      ie_q          <= 1'b0;
`endif
    end else begin
      readdatavalid <= chipselect & read;
      if (chipselect & read) readdata <= rd_data;

      if (wr_en) begin
        if (sel_ctrl) begin
`ifdef STRING_ACCEL_IRQ_EN
          ie_q <= writedata[CtrlIe];
`endif
          if (state_q == StIdle) begin
            ctrl_mode_q <= mode_t'(writedata[CtrlModeLo +: 2]);
            if (writedata[CtrlGo]) begin
              run_mode_q <= mode_t'(writedata[CtrlModeLo +: 2]);
              done_q     <= 1'b0;
              wr_err_q   <= 1'b0;
              noterm_q   <= 1'b0;
              index_q    <= '0;
              result_q   <= '0;
              k_q        <= '0;
              state_q    <= StScan;
            end
          end
        end else if (sel_a) begin
          if (busy) wr_err_q <= 1'b1;
          else      a_q[a_idx] <= writedata;
        end else if (sel_b) begin
          if (busy) wr_err_q <= 1'b1;
          else      b_q[b_idx] <= writedata;
        end
      end

      if (state_q == StScan) begin
        // The copy includes the terminating word, written whole.
        if (run_mode_q == ModeStrcpy) b_q[k_q] <= a_q[k_q];
        if (run_mode_q == ModeRsvd) begin
          result_q <= '1;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end else if (scan_hit) begin
          index_q  <= hit_index;
          result_q <= (run_mode_q == ModeStrcmp) ? {{23{scan_diff[8]}}, scan_diff}
                                                 : 32'(hit_index);
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end else if (k_q == KLast) begin
          noterm_q <= 1'b1;
          result_q <= (run_mode_q == ModeStrcmp) ? 32'd0 : 32'(CHARS_PER_WORD * MAX_WORDS);
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_string_accel_avalon.sv
// Directed bench for string_accel_avalon; read expectations go through a scoreboard queue.
module tb_string_accel_avalon;

  localparam int unsigned MW = 8;
  localparam int unsigned AW = 5;
  localparam int ACtrl = 0;
  localparam int ARes  = 2 * MW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          chipselect, read, write;
  logic [AW-1:0] address;
  logic [31:0]   writedata, readdata;
  logic          readdatavalid;
`ifdef STRING_ACCEL_IRQ_EN
  logic          irq;
`endif

  string_accel_avalon #(
    .MAX_WORDS (MW),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
`ifdef STRING_ACCEL_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered at a falling edge and return one falling edge later.
  task automatic bus_write(input int a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = AW'(a); writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int a, input logic [31:0] e, input string tag);
    chipselect = 1'b1; read = 1'b1; address = AW'(a);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (readdatavalid) begin
      n_asserts++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_readdatavalid: observed 1 expected 0");
      end
      if (exp_q.size() != 0) check(tag_q.pop_front(), readdata, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    idle(2);
    check("reset_rdv", {31'b0, readdatavalid}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    idle(1);
    bus_read(ACtrl, 32'h0, "reset_ctrl");
    bus_read(1, 32'h0, "reset_a0");
    bus_read(MW + 8, 32'h0, "reset_b7");
    bus_read(ARes, 32'h0, "reset_result");

    // "Hello" into A, plus unmapped and read-only writes.
    bus_write(1, 32'h6C6C6548);
    bus_write(2, 32'h0000006F);
    bus_write(20, 32'hDEADBEEF);
    bus_write(ARes, 32'h00001234);
    bus_read(1, 32'h6C6C6548, "a0_rb");
    bus_read(2, 32'h0000006F, "a1_rb");
    bus_read(20, 32'h0, "unmapped_rd");
    bus_read(ARes, 32'h0, "result_ro");

    // STRLEN: DONE appears 2 edges after GO.
    bus_write(ACtrl, 32'h1);
    bus_read(ACtrl, 32'h4, "strlen_busy1");
    bus_read(ACtrl, 32'h4, "strlen_busy2");
    bus_read(ACtrl, 32'h0502, "strlen_done");
    bus_read(ARes, 32'd5, "strlen_result");

    // STRCMP "Hello" vs "Help".
    bus_write(MW + 1, 32'h706C6548);
    bus_write(MW + 2, 32'h0);
    bus_write(ACtrl, 32'h9);
    idle(2);
    bus_read(ACtrl, 32'h030A, "strcmp_ctrl");
    bus_read(ARes, 32'hFFFFFFFC, "strcmp_result");

    // STRCMP identical strings.
    bus_write(MW + 1, 32'h6C6C6548);
    bus_write(MW + 2, 32'h0000006F);
    bus_write(ACtrl, 32'h9);
    idle(3);
    bus_read(ACtrl, 32'h050A, "strcmp_eq_ctrl");
    bus_read(ARes, 32'h0, "strcmp_eq_result");

    // STRCPY into a prefilled B.
    for (int i = 0; i < int'(MW); i++) bus_write(MW + 1 + i, 32'hFFFFFFFF);
    bus_write(ACtrl, 32'h11);
    idle(3);
    bus_read(ACtrl, 32'h0512, "strcpy_ctrl");
    bus_read(ARes, 32'd5, "strcpy_result");
    bus_read(MW + 1, 32'h6C6C6548, "strcpy_b0");
    bus_read(MW + 2, 32'h0000006F, "strcpy_b1");
    bus_read(MW + 3, 32'hFFFFFFFF, "strcpy_b2");
    bus_read(MW + 8, 32'hFFFFFFFF, "strcpy_b7");

    // NOTERM run with a dropped A write and an ignored GO (mode change) while busy.
    for (int i = 0; i < int'(MW); i++) bus_write(1 + i, 32'h41414141);
    bus_write(ACtrl, 32'h1);
    bus_write(4, 32'h12345678);
    bus_write(ACtrl, 32'h11);
    for (int i = 0; i < 6; i++) bus_read(ACtrl, 32'h24, "noterm_busy");
    bus_read(ACtrl, 32'h62, "noterm_done");
    bus_read(ARes, 32'd32, "noterm_result");
    bus_read(4, 32'h41414141, "busy_wr_dropped");
    bus_read(MW + 1, 32'h6C6C6548, "busy_mode_kept");

    // Reserved mode; the new GO also clears WR_ERR and NOTERM.
    bus_write(ACtrl, 32'h19);
    idle(1);
    bus_read(ACtrl, 32'h1A, "rsvd_ctrl");
    bus_read(ARes, 32'hFFFFFFFF, "rsvd_result");

    // Reset in the middle of a long scan.
    bus_write(ACtrl, 32'h1);
    idle(2);
    reset = 1'b1;
    #1;
    check("midreset_rdv", {31'b0, readdatavalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(ACtrl, 32'h0, "midreset_ctrl");
    bus_read(1, 32'h0, "midreset_a0");
    bus_read(MW + 1, 32'h0, "midreset_b0");
    bus_read(ARes, 32'h0, "midreset_result");

`ifdef STRING_ACCEL_IRQ_EN
    bus_write(1, 32'h0);
    bus_write(ACtrl, 32'h80);
    bus_write(ACtrl, 32'h81);
    check("irq_low_after_go", {31'b0, irq}, 32'd0);
    idle(1);
    check("irq_rise", {31'b0, irq}, 32'd1);
    bus_read(ACtrl, 32'h82, "irq_ctrl");
    bus_write(ACtrl, 32'h81);
    check("irq_cleared_by_go", {31'b0, irq}, 32'd0);
    idle(1);
    check("irq_rise2", {31'b0, irq}, 32'd1);
    bus_write(ACtrl, 32'h0);
    check("irq_cleared_by_ie", {31'b0, irq}, 32'd0);
`else
    bus_write(1, 32'h0);
    bus_write(ACtrl, 32'h81);
    idle(1);
    bus_read(ACtrl, 32'h02, "ie_reads_zero");
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
